// File: rtl/dsp_log_pkg.sv
// dsp_log_pkg: shared default widths and the state encoding of the log controller
package dsp_log_pkg;
  localparam int MEM_ADDRESS_LEN_DEF = 15;
  localparam int MEM_DATA_LEN_DEF = 32;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT_TRIG = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_FULL = 2'd3;
endpackage

// File: rtl/log_ram.sv
// log_ram: simple dual-port RAM, synchronous write port and registered read port, no reset
// Ports: clk; we_i/wa_i/wd_i write port; re_i/ra_i read request; rd_o read word (holds when re_i=0)
module log_ram #(
  parameter int AW = 15,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] wa_i,
  input  logic [DW-1:0] wd_i,
  input  logic          re_i,
  input  logic [AW-1:0] ra_i,
  output logic [DW-1:0] rd_o
);
  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rd_q;
  always_ff @(posedge clk) begin
    if (we_i) mem_q[wa_i] <= wd_i;
    if (re_i) rd_q <= mem_q[ra_i];
  end
  assign rd_o = rd_q;
endmodule

// File: rtl/mem_log_controller.sv
// mem_log_controller: captures a burst of datapath samples into a log RAM and serves readback
// Ports: clk, rst (async, active-low); run_log arms on rising edge, aborts when low;
//   sample_in/sample_valid capture input; read_enable/read_address readback request;
//   trigger (LOG_TRIGGER_EN only); mem_data registered readback; mem_full; capturing.
// Build option: define LOG_TRIGGER_EN to add the trigger port and the WAIT_TRIG state.
module mem_log_controller
  import dsp_log_pkg::*;
#(
  parameter int MEM_ADDRESS_LEN = MEM_ADDRESS_LEN_DEF,
  parameter int MEM_DATA_LEN = MEM_DATA_LEN_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       run_log,
  input  logic [MEM_DATA_LEN-1:0]    sample_in,
  input  logic                       sample_valid,
  input  logic                       read_enable,
  input  logic [MEM_ADDRESS_LEN-1:0] read_address,
`ifdef LOG_TRIGGER_EN
  input  logic                       trigger,
`endif
  output logic [MEM_DATA_LEN-1:0]    mem_data,
  output logic                       mem_full,
  output logic                       capturing
);
  logic [1:0] state_q, state_d, start_st;
  logic [MEM_ADDRESS_LEN-1:0] wr_ptr_q, wr_ptr_d;
  logic run_log_d_q, rd_seen_q, trig, active, start, abort, we, re;
  logic [MEM_DATA_LEN-1:0] rd_data;
`ifdef LOG_TRIGGER_EN
  assign trig = trigger;
  assign start_st = ST_WAIT_TRIG;
`else
  assign trig = 1'b0;
  assign start_st = ST_CAPTURE;
`endif
  // A write in WAIT_TRIG happens only on the trigger cycle, landing at address 0.
  always_comb begin
    active = state_q == ST_CAPTURE || state_q == ST_WAIT_TRIG;
    start = run_log && !run_log_d_q && (state_q == ST_IDLE || state_q == ST_FULL);
    abort = active && !run_log;
    we = run_log && sample_valid && (state_q == ST_CAPTURE || (state_q == ST_WAIT_TRIG && trig));
    re = read_enable && state_q != ST_CAPTURE;
    wr_ptr_d = start ? '0 : we ? wr_ptr_q + MEM_ADDRESS_LEN'(1) : wr_ptr_q;
    state_d = start ? start_st :
              abort ? ST_IDLE :
              (we && &wr_ptr_q) ? ST_FULL :
              (state_q == ST_WAIT_TRIG && trig) ? ST_CAPTURE : state_q;
  end
  // The RAM read register has no reset, so mem_data is masked to 0 until the first read after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      wr_ptr_q <= '0;
      run_log_d_q <= 1'b0;
      rd_seen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      run_log_d_q <= run_log;
      rd_seen_q <= rd_seen_q | re;
    end
  end
  log_ram #(.AW(MEM_ADDRESS_LEN), .DW(MEM_DATA_LEN)) u_ram (
    .clk(clk),
    .we_i(we),
    .wa_i(wr_ptr_q),
    .wd_i(sample_in),
    .re_i(re),
    .ra_i(read_address),
    .rd_o(rd_data)
  );
  assign mem_data = rd_seen_q ? rd_data : '0;
  assign mem_full = state_q == ST_FULL;
  assign capturing = active;
endmodule

// File: tb/tb_mem_log_controller.sv
// tb_mem_log_controller: randomized scoreboard bench for mem_log_controller against a behavioural log model
module tb_mem_log_controller;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int M_IDLE = 0, M_WAIT = 1, M_CAP = 2, M_FULL = 3;
`ifdef LOG_TRIGGER_EN
  localparam bit TRIG_EN = 1'b1;
`else
  localparam bit TRIG_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, run_log = 1'b0, sample_valid = 1'b0, read_enable = 1'b0, trigger = 1'b0;
  logic [31:0] sample_in = '0;
  logic [AW-1:0] read_address = '0;
  logic [31:0] mem_data;
  logic mem_full, capturing;
  always #5 clk = ~clk;
  mem_log_controller #(.MEM_ADDRESS_LEN(AW), .MEM_DATA_LEN(32)) dut (
    .clk(clk),
    .rst(rst),
    .run_log(run_log),
    .sample_in(sample_in),
    .sample_valid(sample_valid),
    .read_enable(read_enable),
    .read_address(read_address),
`ifdef LOG_TRIGGER_EN
    .trigger(trigger),
`endif
    .mem_data(mem_data),
    .mem_full(mem_full),
    .capturing(capturing)
  );
  typedef struct { int due; logic [31:0] data; bit dk; bit full; bit capt; } exp_t;
  exp_t sb[$];
  int cyc = 0, checks = 0, errors = 0;
  logic [31:0] mm [DEPTH];
  bit mk [DEPTH];
  int mode = M_IDLE, cnt = 0;
  bit prun = 1'b0;
  logic [31:0] md = '0;
  bit mdk = 1'b1;
  always @(posedge clk) cyc <= cyc + 1;
  // Monitor: every expectation is due at the falling edge after the rising edge it describes.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (e.due != cyc) begin
        errors++;
        $display("FAIL stale_expectation due=%0d now=%0d", e.due, cyc);
      end
      checks++;
      if (mem_full !== e.full) begin
        errors++;
        $display("FAIL mem_full cyc=%0d got=%b exp=%b", cyc, mem_full, e.full);
      end
      checks++;
      if (capturing !== e.capt) begin
        errors++;
        $display("FAIL capturing cyc=%0d got=%b exp=%b", cyc, capturing, e.capt);
      end
      if (e.dk) begin
        checks++;
        if (mem_data !== e.data) begin
          errors++;
          $display("FAIL mem_data cyc=%0d got=%h exp=%h", cyc, mem_data, e.data);
        end
      end
    end
  end
  task automatic push_exp();
    sb.push_back('{cyc + 1, md, mdk, mode == M_FULL, mode == M_WAIT || mode == M_CAP});
  endtask
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    run_log = 1'b0;
    sample_valid = 1'b0;
    read_enable = 1'b0;
    trigger = 1'b0;
    mode = M_IDLE;
    cnt = 0;
    prun = 1'b0;
    md = '0;
    mdk = 1'b1;
    push_exp();
  endtask
  task automatic step(input bit run, input bit valid, input logic [31:0] din, input bit ren, input logic [AW-1:0] ra, input bit trg);
    bit wr;
    @(negedge clk);
    #1;
    rst = 1'b1;
    run_log = run;
    sample_valid = valid;
    sample_in = din;
    read_enable = ren;
    read_address = ra;
    trigger = trg;
    wr = run && valid && (mode == M_CAP || (mode == M_WAIT && trg));
    if (ren && mode != M_CAP) begin
      md = mm[ra];
      mdk = mk[ra];
    end
    if ((mode == M_IDLE || mode == M_FULL) && run && !prun) begin
      mode = TRIG_EN ? M_WAIT : M_CAP;
      cnt = 0;
    end else if ((mode == M_CAP || mode == M_WAIT) && !run) begin
      mode = M_IDLE;
    end else begin
      if (mode == M_WAIT && trg) mode = M_CAP;
      if (wr) begin
        mm[cnt] = din;
        mk[cnt] = 1'b1;
        cnt++;
        if (cnt == DEPTH) begin
          mode = M_FULL;
          cnt = 0;
        end
      end
    end
    prun = run;
    push_exp();
  endtask
  task automatic read_all(input bit run);
    for (int i = 0; i < DEPTH; i++) step(run, 1'b0, '0, 1'b1, AW'(i), 1'b0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog bench did not finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < DEPTH; i++) mk[i] = 1'b0;
    do_reset();
    step(0, 0, '0, 0, '0, 0);
    step(0, 0, '0, 0, '0, 0);
    // Continuous capture of 0xA0000000+n, then readback.
    step(1, 0, '0, 0, '0, 0);
    for (int n = 0; n < DEPTH; n++) step(1, 1, 32'hA000_0000 + 32'(n), 0, '0, 1);
    step(1, 0, '0, 1, 4'd5, 0);
    step(1, 0, '0, 0, '0, 0);
    read_all(1);
    // Same-edge read and capture start returns pre-capture data.
    step(0, 0, '0, 0, '0, 0);
    step(1, 1, 32'h1234_5678, 1, 4'd0, 0);
    // Toggling sample_valid.
    for (int i = 0; i < 2 * DEPTH; i++) step(1, i % 2 == 0, $urandom, 0, '0, 1);
    read_all(1);
    // Abort after 7 writes; address 7 keeps its old word.
    step(0, 0, '0, 0, '0, 0);
    step(1, 0, '0, 0, '0, 0);
    for (int i = 0; i < 7; i++) step(1, 1, $urandom, 0, '0, 1);
    step(0, 1, $urandom, 0, '0, 1);
    for (int i = 0; i < 8; i++) step(0, 0, '0, 1, AW'(i), 0);
    // Read during capture is ignored; works once full.
    step(1, 0, '0, 0, '0, 0);
    for (int n = 0; n < DEPTH; n++) step(1, 1, $urandom, 1, 4'd3, 1);
    step(1, 0, '0, 1, 4'd3, 0);
    // Falling run_log in FULL is ignored; a new rising edge restarts from address 0.
    step(0, 0, '0, 0, '0, 0);
    step(0, 0, '0, 1, 4'd3, 0);
    step(1, 0, '0, 0, '0, 0);
    for (int n = 0; n < DEPTH; n++) step(1, 1, $urandom, 0, '0, 1);
    step(1, 0, '0, 1, 4'd0, 0);
`ifdef LOG_TRIGGER_EN
    // Trigger arrives 10 cycles after the run edge; only the trigger-cycle sample onward is logged.
    step(0, 0, '0, 0, '0, 0);
    step(1, 1, $urandom, 0, '0, 0);
    for (int i = 0; i < 9; i++) step(1, 1, $urandom, 0, '0, 0);
    step(1, 1, 32'hCAFE_0000, 0, '0, 1);
    for (int i = 0; i < 3; i++) step(1, 1, $urandom, 0, '0, 0);
`else
    step(0, 0, '0, 0, '0, 0);
    step(1, 0, '0, 0, '0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, $urandom, 0, '0, 0);
`endif
    // Reset mid-capture clears outputs and keeps RAM contents.
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 0, '0, 1, AW'(i), 0);
    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bit r;
      r = ($urandom_range(0, 19) == 0) ? !prun : prun;
      step(r, $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) == 1, AW'($urandom_range(0, DEPTH - 1)), $urandom_range(0, 7) == 0);
    end
    read_all(0);
    for (int i = 0; i < 3; i++) step(0, 0, '0, 0, '0, 0);
    @(negedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
